// File: rtl/decode_exception_controller_pkg.sv
// Shared types for the decode-stage exception controller: RISC-V encodings
// and causes (riscv_types), core configuration and decode state (cva5_types).
package riscv_types;
    localparam logic [4:0] ILLEGAL_INST = 5'd2;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_WFI    = 32'h1050_0073;
endpackage

package cva5_types;
    typedef struct packed {
        logic include_m_unit;
        logic include_csrs;
        logic include_fence_i;
    } cpu_config_t;

    localparam cpu_config_t EXAMPLE_CONFIG = '{
        include_m_unit:  1'b1,
        include_csrs:    1'b1,
        include_fence_i: 1'b1
    };

    typedef enum logic [1:0] {
        EMPTY,
        HOLD_LEGAL,
        HOLD_ILLEGAL
    } decode_exc_state_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] tval;
    } decode_exception_t;
endpackage

// File: rtl/decode_exception_controller_checker.sv
// Combinational RV32I(+M, Zicsr, Zifencei by CONFIG) legality check of one
// 32-bit instruction word.
module illegal_instruction_checker
    import riscv_types::*;
    import cva5_types::*;
#(
    parameter cpu_config_t CONFIG = EXAMPLE_CONFIG
) (
    input  logic [31:0] instruction,
    output logic        illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            OPC_JALR:   legal = (funct3 == 3'd0);
            OPC_BRANCH: legal = (funct3 != 3'd2) && (funct3 != 3'd3);
            OPC_LOAD:   legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                                (funct3 == 3'd4) || (funct3 == 3'd5);
            OPC_STORE:  legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
            OPC_OP_IMM: begin
                // only the shift-immediates constrain funct7
                if (funct3 == 3'd1)
                    legal = (funct7 == 7'h00);
                else if (funct3 == 3'd5)
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                else
                    legal = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == 7'h00)
                    legal = 1'b1;
                else if (funct7 == 7'h20)
                    legal = (funct3 == 3'd0) || (funct3 == 3'd5);
                else if (funct7 == 7'h01)
                    legal = CONFIG.include_m_unit;
                else
                    legal = 1'b0;
            end
            OPC_MISC_MEM: legal = (funct3 == 3'd0) || ((funct3 == 3'd1) && CONFIG.include_fence_i);
            OPC_SYSTEM: begin
                if (funct3 == 3'd0)
                    legal = (instruction == INST_ECALL) || (instruction == INST_EBREAK) ||
                            (instruction == INST_MRET)  || (instruction == INST_WFI);
                else if (funct3 == 3'd4)
                    legal = 1'b0;
                else
                    legal = CONFIG.include_csrs;
            end
            default: legal = 1'b0;
        endcase
    end

    assign illegal = !legal;
endmodule

// File: rtl/decode_exception_controller.sv
// Single-entry decode register: legal instructions go to issue, illegal ones
// raise an exception until ack/flush. Define DECODE_EXCEPTION_TVAL_EN to report tval.
module decode_exception_controller
    import riscv_types::*;
    import cva5_types::*;
#(
    parameter cpu_config_t CONFIG = EXAMPLE_CONFIG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_instruction,
    input  logic [31:0] fetch_pc,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] issue_instruction,
    output logic [31:0] issue_pc,
    output logic        exception_valid,
    output logic [4:0]  exception_code,
    output logic [31:0] exception_pc,
    output logic [31:0] exception_tval,
    input  logic        exception_ack
);
    decode_exc_state_t state;
    decode_exception_t exception;
    logic [31:0]       held_instruction;
    logic [31:0]       held_pc;
    logic              held_illegal;
    logic              fetch_illegal;
    logic              accept;

    illegal_instruction_checker #(.CONFIG(CONFIG)) illegal_checker (
        .instruction (fetch_instruction),
        .illegal     (fetch_illegal)
    );

    // HOLD_LEGAL reloads in the same cycle issue drains it, giving full throughput
    assign fetch_ready = !rst && !flush &&
                         ((state == EMPTY) || ((state == HOLD_LEGAL) && issue_ready));
    assign accept      = fetch_valid && fetch_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= EMPTY;
            held_instruction <= 32'd0;
            held_pc          <= 32'd0;
            issue_valid      <= 1'b0;
            held_illegal     <= 1'b0;
        end else if (flush) begin
            state        <= EMPTY;
            issue_valid  <= 1'b0;
            held_illegal <= 1'b0;
        end else if (accept) begin
            held_instruction <= fetch_instruction;
            held_pc          <= fetch_pc;
            state            <= fetch_illegal ? HOLD_ILLEGAL : HOLD_LEGAL;
            issue_valid      <= !fetch_illegal;
            held_illegal     <= fetch_illegal;
        end else begin
            case (state)
                HOLD_LEGAL: begin
                    if (issue_ready) begin
                        state       <= EMPTY;
                        issue_valid <= 1'b0;
                    end
                end
                HOLD_ILLEGAL: begin
                    if (exception_ack) begin
                        state        <= EMPTY;
                        held_illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign exception.valid = held_illegal;
    assign exception.code  = ILLEGAL_INST;
    assign exception.pc    = held_pc;
`ifdef DECODE_EXCEPTION_TVAL_EN
    assign exception.tval  = held_illegal ? held_instruction : 32'd0;
`else
    assign exception.tval  = 32'd0;
`endif

    assign issue_instruction = held_instruction;
    assign issue_pc          = held_pc;
    assign exception_valid   = exception.valid;
    assign exception_code    = exception.code;
    assign exception_pc      = exception.pc;
    assign exception_tval    = exception.tval;
endmodule
